// File: rtl/mips_pkg.sv
// Shared constants and types for the MIPS core front end.
// Holds the instruction-memory geometry and the fetch FSM encoding.
package mips_pkg;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam int          IM_WORDS = 1024;
  localparam int          IM_AW    = $clog2(IM_WORDS);
  localparam logic [31:0] NOP      = 32'h0000_0000;

  typedef enum logic [1:0] {
    IFU_BOOT = 2'd0,
    IFU_RUN  = 2'd1,
    IFU_ERR  = 2'd2
  } ifu_state_e;

  // True when a byte PC is word aligned and lands inside the instruction window.
  function automatic logic pc_ok(input logic [31:0] pc,
                                 input logic [31:0] base,
                                 input logic [31:0] window_bytes);
    logic [31:0] offset;
    offset = pc - base;
    return (pc[1:0] == 2'b00) && (offset < window_bytes);
  endfunction

endpackage

// File: rtl/ifu_if.sv
// Fetch-side bundle: instruction-memory port, hazard/redirect controls and IF/ID outputs.
// The master modport is the fetch unit; the slave modport is the surrounding pipeline.
interface ifu_if;
  import mips_pkg::*;

  logic [IM_AW-1:0] imem_addr;
  logic [31:0]      imem_dout;
  logic             stall;
  logic             redirect_valid;
  logic [31:0]      redirect_pc;
  logic             ifid_valid;
  logic [31:0]      ifid_instr;
  logic [31:0]      ifid_pc;
  logic [31:0]      ifid_pc4;
  logic             fetch_err;

  modport master (
    output imem_addr,
    input  imem_dout,
    input  stall,
    input  redirect_valid,
    input  redirect_pc,
    output ifid_valid,
    output ifid_instr,
    output ifid_pc,
    output ifid_pc4,
    output fetch_err
  );

  modport slave (
    input  imem_addr,
    output imem_dout,
    output stall,
    output redirect_valid,
    output redirect_pc,
    input  ifid_valid,
    input  ifid_instr,
    input  ifid_pc,
    input  ifid_pc4,
    input  fetch_err
  );

endinterface

// File: rtl/ifu_ifid_reg.sv
// IF/ID pipeline register: loads on enable, flush only drops the valid bit.
// Flush has priority over load so a redirect never lets a stale word through.
module ifid_reg
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        flush,
  input  logic [31:0] fetch_instr,
  input  logic [31:0] fetch_pc,
  input  logic [31:0] fetch_pc4,
  output logic        valid,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic [31:0] pc4
);

  logic        valid_reg;
  logic [31:0] instr_reg;
  logic [31:0] pc_reg;
  logic [31:0] pc4_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_reg <= 1'b0;
      instr_reg <= NOP;
      pc_reg    <= 32'd0;
      pc4_reg   <= 32'd0;
    end else if (flush) begin
      valid_reg <= 1'b0;
    end else if (en) begin
      valid_reg <= 1'b1;
      instr_reg <= fetch_instr;
      pc_reg    <= fetch_pc;
      pc4_reg   <= fetch_pc4;
    end
  end

  assign valid = valid_reg;
  assign instr = instr_reg;
  assign pc    = pc_reg;
  assign pc4   = pc4_reg;

endmodule

// File: rtl/ifu.sv
// Instruction fetch unit: owns the PC, sequences fetch against stall/redirect,
// and traps into a sticky error state on misaligned or out-of-window PCs.
module ifu #(
  parameter logic [31:0] RESET_PC = mips_pkg::RESET_PC,
  parameter int          IM_WORDS = mips_pkg::IM_WORDS
) (
  input  logic   clk,
  input  logic   rst_n,
  ifu_if.master  bus
);
  import mips_pkg::*;

  localparam int          AW           = $clog2(IM_WORDS);
  localparam logic [31:0] WINDOW_BYTES = 32'(IM_WORDS) << 2;

  ifu_state_e  state_reg;
  logic [31:0] pc_reg;
  logic        fetch_err_reg;
  logic [31:0] pc_plus4;
  logic        in_run;
  logic        load;
  logic        flush;

  assign pc_plus4 = pc_reg + 32'd4;
  assign in_run   = (state_reg == IFU_RUN);
  assign load     = in_run && !bus.redirect_valid && !bus.stall;
  assign flush    = (in_run && bus.redirect_valid) || (state_reg == IFU_ERR);

  // Word index relative to the window base; wraps like the 32-bit offset it comes from.
  assign bus.imem_addr = AW'((pc_reg - RESET_PC) >> 2);
  assign bus.fetch_err = fetch_err_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IFU_BOOT;
      pc_reg        <= RESET_PC;
      fetch_err_reg <= 1'b0;
    end else begin
      case (state_reg)
        IFU_BOOT: state_reg <= IFU_RUN;
        IFU_RUN: begin
          if (bus.redirect_valid) begin
            pc_reg <= bus.redirect_pc;
            if (!pc_ok(bus.redirect_pc, RESET_PC, WINDOW_BYTES)) begin
              state_reg     <= IFU_ERR;
              fetch_err_reg <= 1'b1;
            end
          end else if (!bus.stall) begin
            pc_reg <= pc_plus4;
            // The last word is still handed to IF/ID on this same edge.
            if (!pc_ok(pc_plus4, RESET_PC, WINDOW_BYTES)) begin
              state_reg     <= IFU_ERR;
              fetch_err_reg <= 1'b1;
            end
          end
        end
        IFU_ERR: state_reg <= IFU_ERR;
        default: begin
          state_reg     <= IFU_ERR;
          fetch_err_reg <= 1'b1;
        end
      endcase
    end
  end

  ifid_reg u_ifid_reg (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (load),
    .flush       (flush),
    .fetch_instr (bus.imem_dout),
    .fetch_pc    (pc_reg),
    .fetch_pc4   (pc_plus4),
    .valid       (bus.ifid_valid),
    .instr       (bus.ifid_instr),
    .pc          (bus.ifid_pc),
    .pc4         (bus.ifid_pc4)
  );

endmodule

// File: tb/tb_ifu.sv
// Self-checking bench for ifu: directed scenarios plus a randomized run
// compared against a behavioural fetch model.
module tb_ifu;
  import mips_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ifu_if bus();

  ifu dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [31:0] mem [IM_WORDS];
  assign bus.imem_dout = mem[bus.imem_addr];

  int checks = 0;
  int errors = 0;

  // Behavioural model of the architectural fetch state.
  bit          m_boot, m_err, m_valid, m_ferr;
  logic [31:0] m_pc, m_instr, m_ipc, m_ipc4;

  function automatic bit target_ok(input logic [31:0] a);
    logic [31:0] off;
    off = a - RESET_PC;
    return (a[1:0] == 2'b00) && (off < 32'(IM_WORDS * 4));
  endfunction

  function automatic logic [IM_AW-1:0] model_addr();
    logic [31:0] off;
    off = m_pc - RESET_PC;
    return off[IM_AW+1:2];
  endfunction

  task automatic tick(input bit r, input bit st, input bit rv, input logic [31:0] rpc);
    logic [31:0] off;
    rst_n = r;
    bus.stall = st;
    bus.redirect_valid = rv;
    bus.redirect_pc = rpc;
    if (!r) begin
      m_boot = 1; m_err = 0; m_pc = RESET_PC; m_valid = 0;
      m_instr = 0; m_ipc = 0; m_ipc4 = 0; m_ferr = 0;
    end else if (m_boot) begin
      m_boot = 0;
    end else if (m_err) begin
      m_valid = 0;
    end else if (rv) begin
      m_pc = rpc;
      m_valid = 0;
      if (!target_ok(rpc)) begin m_err = 1; m_ferr = 1; end
    end else if (!st) begin
      off = m_pc - RESET_PC;
      m_instr = mem[off[IM_AW+1:2]];
      m_ipc = m_pc;
      m_ipc4 = m_pc + 32'd4;
      m_valid = 1;
      m_pc = m_pc + 32'd4;
      if (!target_ok(m_pc)) begin m_err = 1; m_ferr = 1; end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < IM_WORDS; i++) mem[i] = 32'(i);
    tick(0, 0, 0, 32'h0);
    tick(0, 1, 1, 32'h3100);
    checks++;
    if ({bus.ifid_valid, bus.ifid_instr, bus.ifid_pc, bus.ifid_pc4, bus.fetch_err, bus.imem_addr} !==
        {1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 10'd0}) begin
      errors++;
      $display("FAIL reset_state got v=%0b i=%h pc=%h pc4=%h err=%0b addr=%h want all zero",
               bus.ifid_valid, bus.ifid_instr, bus.ifid_pc, bus.ifid_pc4, bus.fetch_err, bus.imem_addr);
    end
  endtask

  task automatic test_free_run();
    tick(1, 1, 1, 32'h3200);
    checks++;
    if ({bus.ifid_valid, bus.imem_addr} !== {1'b0, 10'd0}) begin
      errors++;
      $display("FAIL boot_cycle got v=%0b addr=%h want v=0 addr=0", bus.ifid_valid, bus.imem_addr);
    end
    for (int k = 0; k < 2; k++) begin
      tick(1, 0, 0, 32'h0);
      checks++;
      if ({bus.ifid_valid, bus.ifid_pc, bus.ifid_instr, bus.ifid_pc4} !==
          {1'b1, 32'h3000 + 32'(4 * k), 32'(k), 32'h3004 + 32'(4 * k)}) begin
        errors++;
        $display("FAIL free_run_%0d got v=%0b pc=%h i=%h pc4=%h want pc=%h i=%0d",
                 k, bus.ifid_valid, bus.ifid_pc, bus.ifid_instr, bus.ifid_pc4, 32'h3000 + 32'(4 * k), k);
      end
    end
  endtask

  task automatic test_stall();
    for (int k = 0; k < 3; k++) begin
      tick(1, 1, 0, 32'h0);
      checks++;
      if ({bus.imem_addr, bus.ifid_valid, bus.ifid_pc, bus.ifid_instr} !== {10'd2, 1'b1, 32'h3004, 32'd1}) begin
        errors++;
        $display("FAIL stall_hold_%0d got addr=%h v=%0b pc=%h i=%h want addr=2 pc=3004 i=1",
                 k, bus.imem_addr, bus.ifid_valid, bus.ifid_pc, bus.ifid_instr);
      end
    end
    tick(1, 0, 0, 32'h0);
    checks++;
    if ({bus.ifid_valid, bus.ifid_pc, bus.ifid_instr, bus.imem_addr} !== {1'b1, 32'h3008, 32'd2, 10'd3}) begin
      errors++;
      $display("FAIL stall_resume got v=%0b pc=%h i=%h addr=%h want pc=3008 i=2 addr=3",
               bus.ifid_valid, bus.ifid_pc, bus.ifid_instr, bus.imem_addr);
    end
  endtask

  task automatic test_redirect_stall();
    tick(1, 1, 1, 32'h3100);
    checks++;
    if ({bus.ifid_valid, bus.imem_addr} !== {1'b0, 10'h40}) begin
      errors++;
      $display("FAIL redirect_flush got v=%0b addr=%h want v=0 addr=40", bus.ifid_valid, bus.imem_addr);
    end
    tick(1, 0, 0, 32'h0);
    checks++;
    if ({bus.ifid_valid, bus.ifid_pc, bus.ifid_instr, bus.ifid_pc4} !== {1'b1, 32'h3100, 32'h40, 32'h3104}) begin
      errors++;
      $display("FAIL redirect_target got v=%0b pc=%h i=%h pc4=%h want pc=3100 i=40 pc4=3104",
               bus.ifid_valid, bus.ifid_pc, bus.ifid_instr, bus.ifid_pc4);
    end
  endtask

  task automatic test_misaligned();
    tick(1, 0, 1, 32'h3102);
    checks++;
    if ({bus.fetch_err, bus.ifid_valid, bus.imem_addr} !== {1'b1, 1'b0, 10'h40}) begin
      errors++;
      $display("FAIL misaligned_enter got err=%0b v=%0b addr=%h want err=1 v=0 addr=40",
               bus.fetch_err, bus.ifid_valid, bus.imem_addr);
    end
    for (int k = 0; k < 10; k++) begin
      tick(1, 1'($urandom_range(0, 1)), 1'(k % 2), 32'h3200);
      checks++;
      if ({bus.fetch_err, bus.ifid_valid, bus.imem_addr} !== {1'b1, 1'b0, 10'h40}) begin
        errors++;
        $display("FAIL err_frozen_%0d got err=%0b v=%0b addr=%h want err=1 v=0 addr=40",
                 k, bus.fetch_err, bus.ifid_valid, bus.imem_addr);
      end
    end
  endtask

  task automatic test_reset_in_err();
    tick(0, 0, 1, 32'h3200);
    checks++;
    if ({bus.fetch_err, bus.ifid_valid, bus.imem_addr} !== {1'b0, 1'b0, 10'd0}) begin
      errors++;
      $display("FAIL err_reset got err=%0b v=%0b addr=%h want all zero",
               bus.fetch_err, bus.ifid_valid, bus.imem_addr);
    end
    tick(1, 0, 0, 32'h0);
    tick(1, 0, 0, 32'h0);
    tick(1, 0, 0, 32'h0);
    checks++;
    if ({bus.ifid_valid, bus.ifid_pc, bus.ifid_instr, bus.fetch_err} !== {1'b1, 32'h3004, 32'd1, 1'b0}) begin
      errors++;
      $display("FAIL restart_fetch got v=%0b pc=%h i=%h err=%0b want pc=3004 i=1 err=0",
               bus.ifid_valid, bus.ifid_pc, bus.ifid_instr, bus.fetch_err);
    end
  endtask

  task automatic test_last_word();
    tick(1, 0, 1, 32'h3FF8);
    tick(1, 0, 0, 32'h0);
    checks++;
    if ({bus.ifid_valid, bus.ifid_pc, bus.ifid_instr, bus.fetch_err} !== {1'b1, 32'h3FF8, 32'd1022, 1'b0}) begin
      errors++;
      $display("FAIL penultimate_word got v=%0b pc=%h i=%0d err=%0b want pc=3ff8 i=1022 err=0",
               bus.ifid_valid, bus.ifid_pc, bus.ifid_instr, bus.fetch_err);
    end
    tick(1, 0, 0, 32'h0);
    checks++;
    if ({bus.ifid_valid, bus.ifid_pc, bus.ifid_instr, bus.fetch_err} !== {1'b1, 32'h3FFC, 32'd1023, 1'b1}) begin
      errors++;
      $display("FAIL last_word got v=%0b pc=%h i=%0d err=%0b want v=1 pc=3ffc i=1023 err=1",
               bus.ifid_valid, bus.ifid_pc, bus.ifid_instr, bus.fetch_err);
    end
    tick(1, 0, 0, 32'h0);
    checks++;
    if ({bus.ifid_valid, bus.fetch_err} !== {1'b0, 1'b1}) begin
      errors++;
      $display("FAIL after_last_word got v=%0b err=%0b want v=0 err=1", bus.ifid_valid, bus.fetch_err);
    end
    tick(0, 0, 0, 32'h0);
    tick(1, 0, 0, 32'h0);
    tick(1, 0, 1, 32'h2FFC);
    checks++;
    if ({bus.ifid_valid, bus.fetch_err} !== {1'b0, 1'b1}) begin
      errors++;
      $display("FAIL below_window got v=%0b err=%0b want v=0 err=1", bus.ifid_valid, bus.fetch_err);
    end
  endtask

  task automatic test_random();
    bit          r, st, rv;
    logic [31:0] tgt;
    for (int i = 0; i < IM_WORDS; i++) mem[i] = $urandom;
    tick(0, 0, 0, 32'h0);
    for (int n = 0; n < 400; n++) begin
      r  = ($urandom_range(0, 99) >= 3);
      st = ($urandom_range(0, 99) < 30);
      rv = ($urandom_range(0, 99) < 12);
      case ($urandom_range(0, 19))
        0:       tgt = RESET_PC + 32'($urandom_range(0, 4095)) | 32'h1;
        1:       tgt = RESET_PC - 32'd4;
        2:       tgt = RESET_PC + 32'(IM_WORDS * 4);
        3:       tgt = RESET_PC + 32'(IM_WORDS * 4) - 32'd8;
        default: tgt = RESET_PC + (32'($urandom_range(0, IM_WORDS - 1)) << 2);
      endcase
      tick(r, st, rv, tgt);
      checks++;
      if ({bus.ifid_valid, bus.ifid_instr, bus.ifid_pc, bus.ifid_pc4, bus.fetch_err, bus.imem_addr} !==
          {m_valid, m_instr, m_ipc, m_ipc4, m_ferr, model_addr()}) begin
        errors++;
        $display("FAIL random_%0d got v=%0b i=%h pc=%h pc4=%h err=%0b addr=%h want v=%0b i=%h pc=%h pc4=%h err=%0b addr=%h",
                 n, bus.ifid_valid, bus.ifid_instr, bus.ifid_pc, bus.ifid_pc4, bus.fetch_err, bus.imem_addr,
                 m_valid, m_instr, m_ipc, m_ipc4, m_ferr, model_addr());
      end
    end
  endtask

  initial begin
    bus.stall = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = 32'h0;
    test_reset();
    test_free_run();
    test_stall();
    test_redirect_stall();
    test_misaligned();
    test_reset_in_err();
    test_last_word();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ifu.md
# ifu

Instruction fetch unit for the pipelined MIPS core: owns the program counter, drives the word address of the 4 KiB instruction memory (`im_4k`, combinational read, 1024 × 32-bit words), and registers the fetched word into the IF/ID stage register. It sequences fetch against pipeline stall, branch/jump redirect and fetch-fault conditions. It sits between `im_4k` and the decode stage.

## Interface
- `RESET_PC`, 32'h0000_3000, byte address of the first instruction; maps to `im_4k` word 0.
- `IM_WORDS`, 1024, instruction-memory depth in words; must be a power of two.

- `clk`  in  1  system clock, all state on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `imem_addr`  out  10  word address to `im_4k` (`addr[11:2]`).
- `imem_dout`  in  32  instruction word from `im_4k`, valid in the same cycle as `imem_addr`.
- `stall`  in  1  hold PC and IF/ID contents (hazard unit).
- `redirect_valid`  in  1  taken branch/jump from EX; flushes IF/ID.
- `redirect_pc`  in  32  byte target of the redirect.
- `ifid_valid`  out  1  IF/ID holds a real instruction.
- `ifid_instr`  out  32  registered instruction.
- `ifid_pc`  out  32  byte PC of `ifid_instr`.
- `ifid_pc4`  out  32  `ifid_pc + 4`.
- `fetch_err`  out  1  sticky fault: misaligned or out-of-window PC.

## Operation
- `offset = pc - RESET_PC` (32-bit, wraps). `imem_addr = offset[11:2]` (combinational from `pc`).
- `in_window = (offset < IM_WORDS*4)`. `aligned = (pc[1:0] == 0)`.
- FSM states: BOOT, RUN, ERR.
  - BOOT: entered on reset; `pc = RESET_PC`, `ifid_valid = 0`. Leaves to RUN after one cycle unconditionally (stall/redirect ignored in BOOT).
  - RUN, per rising edge, in priority order:
    1. `redirect_valid`: `pc <= redirect_pc`, `ifid_valid <= 0`. If `redirect_pc` is misaligned or outside the window, go to ERR. Redirect overrides `stall`.
    2. `stall`: `pc` and all IF/ID registers hold.
    3. Otherwise: `ifid_instr <= imem_dout`, `ifid_pc <= pc`, `ifid_pc4 <= pc + 4`, `ifid_valid <= 1`, `pc <= pc + 4`. If `pc + 4` leaves the window (the last word was fetched), go to ERR. The last word is still delivered valid.
  - ERR: `fetch_err = 1`, `ifid_valid <= 0`, `pc` frozen. All inputs ignored. Only reset exits.
- Reset values: `pc = RESET_PC`, `ifid_valid = 0`, `ifid_instr = 0`, `ifid_pc = 0`, `ifid_pc4 = 0`, `fetch_err = 0`, state BOOT.
- Reset asserted mid-operation wins over every other input in that cycle.
- All adds are 32-bit modulo; no carry-out is kept.

## Timing
- Fetch-to-IF/ID latency: 1 cycle. The word at `pc` in cycle N appears on `ifid_instr` after edge N+1.
- First valid instruction: `ifid_valid = 1` two edges after `rst_n` deasserts (BOOT, then first RUN fetch).
- Redirect: `ifid_valid = 0` for exactly one cycle. The target instruction is valid on the following edge if `stall` is low.
- `stall` and `redirect_valid` both high: the redirect is taken and the stall is dropped for that cycle.
- `fetch_err` rises on the edge that enters ERR, and `ifid_valid` is 0 from that edge on.
- `imem_addr` changes only on clock edges (it is a function of registered `pc`).

## Structure
- Shared package `mips_pkg`: `RESET_PC` default, `IM_WORDS`, the state encoding (`IFU_BOOT`, `IFU_RUN`, `IFU_ERR`), and the NOP constant 32'h0000_0000.
- One natural sub-module: `ifid_reg`, the IF/ID register with enable (`!stall`) and synchronous flush. `ifu` keeps the PC, the FSM and the window check.
- `im_4k` is instantiated by the top level, not inside `ifu`.

## Test plan
- Reset then free-run, no stall, memory word i = i: `ifid_pc` = 0x3000, 0x3004, 0x3008 on consecutive cycles, `ifid_instr` = 0, 1, 2; `ifid_valid` is low for the first edge after reset.
- Stall for 3 cycles at `pc` = 0x3008: `imem_addr` stays 2 and IF/ID holds 0x3004/1 for 3 cycles. Fetch resumes with 0x3008/2.
- Redirect to 0x3100 asserted together with `stall`: next cycle `ifid_valid` = 0 and `imem_addr` = 0x40; the following cycle `ifid_pc` = 0x3100 and `ifid_valid` = 1.
- Redirect to 0x3102 (misaligned): `fetch_err` = 1 on the next edge, `ifid_valid` = 0, `pc` frozen at 0x3102 for 10+ cycles despite further redirects.
- Run to the last word (0x3FFC): word 1023 is delivered valid, then `fetch_err` = 1. A redirect to 0x2FFC is also verified to enter ERR.
- Pull `rst_n` low for one cycle mid-run while in ERR: the next state is BOOT, `fetch_err` = 0, `pc` = 0x3000, and the normal fetch sequence restarts.
